// File: rtl/alu_wrapper_pkg.sv
// Shared ALU definitions: function codes and default datapath width.
package alu_wrapper_pkg;

   localparam int unsigned AluDefWidth = 64;

   typedef enum logic [1:0] {
      ALUADD = 2'd0,
      ALUSUB = 2'd1,
      ALUAND = 2'd2,
      ALUXOR = 2'd3
   } alu_fun_e;

endpackage

// File: rtl/alu_add64.sv
// WIDTH-bit adder with carry-in; carry out is intentionally not produced.
module alu_add64 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o
);

   assign sum_o = a_i + b_i + WIDTH'(cin_i);

endmodule

// File: rtl/alu_wrapper.sv
// Y86-style ALU: combinational result/overflow plus a one-cycle registered copy.
module alu_wrapper
   import alu_wrapper_pkg::*;
#(
   parameter int unsigned WIDTH = AluDefWidth
) (
   output logic             OF,
   output logic [WIDTH-1:0] out,
   input  logic [1:0]       fun,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] a,
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out_q,
   output logic             OF_q
);

   localparam int unsigned Msb = WIDTH - 1;

   logic             is_sub;
   logic [WIDTH-1:0] add_opnd;
   logic [WIDTH-1:0] sum;

   // Subtraction reuses the adder as b + ~a + 1.
   assign is_sub   = (alu_fun_e'(fun) == ALUSUB);
   assign add_opnd = is_sub ? ~a : a;

   alu_add64 #(
      .WIDTH (WIDTH)
   ) u_add (
      .a_i   (add_opnd),
      .b_i   (b),
      .cin_i (is_sub),
      .sum_o (sum)
   );

   always_comb begin
      out = sum;
      OF  = 1'b0;
      unique case (alu_fun_e'(fun))
         ALUADD: begin
            out = sum;
            OF  = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
         end
         ALUSUB: begin
            out = sum;
            OF  = (b[Msb] != a[Msb]) && (sum[Msb] != b[Msb]);
         end
         ALUAND: out = b & a;
         ALUXOR: out = b ^ a;
         default: begin
            out = sum;
            OF  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         OF_q  <= 1'b0;
      end else begin
         out_q <= out;
         OF_q  <= OF;
      end
   end

endmodule

// File: tb/tb_alu_wrapper.sv
// Directed self-checking bench for alu_wrapper with hand-computed vectors.
module tb_alu_wrapper;

   logic        clk;
   logic        reset;
   logic [1:0]  fun;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] out;
   logic        OF;
   logic [63:0] out_q;
   logic        OF_q;

   int checks = 0;
   int errors = 0;

   alu_wrapper #(
      .WIDTH (64)
   ) dut (
      .OF    (OF),
      .out   (out),
      .fun   (fun),
      .b     (b),
      .a     (a),
      .clk   (clk),
      .reset (reset),
      .out_q (out_q),
      .OF_q  (OF_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] f, input logic [63:0] bv, input logic [63:0] av);
      fun = f;
      b   = bv;
      a   = av;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      fun   = 2'd0;
      a     = 64'd0;
      b     = 64'd0;

      tick();
      check("reset_out_q", out_q, 64'd0);
      check("reset_OF_q", {63'd0, OF_q}, 64'd0);
      reset = 1'b0;

      drive(2'd0, 64'd5, 64'd3);
      check("add_out", out, 64'd8);
      check("add_OF", {63'd0, OF}, 64'd0);
      tick();
      check("add_out_q", out_q, 64'd8);
      check("add_OF_q", {63'd0, OF_q}, 64'd0);

      drive(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      check("add_ovf_out", out, 64'h8000_0000_0000_0000);
      check("add_ovf_OF", {63'd0, OF}, 64'd1);
      tick();
      check("add_ovf_out_q", out_q, 64'h8000_0000_0000_0000);
      check("add_ovf_OF_q", {63'd0, OF_q}, 64'd1);

      drive(2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      check("add_negovf_out", out, 64'd0);
      check("add_negovf_OF", {63'd0, OF}, 64'd1);

      drive(2'd1, 64'd10, 64'd3);
      check("sub_out", out, 64'd7);
      check("sub_OF", {63'd0, OF}, 64'd0);

      drive(2'd1, 64'h8000_0000_0000_0000, 64'd1);
      check("sub_ovf_out", out, 64'h7FFF_FFFF_FFFF_FFFF);
      check("sub_ovf_OF", {63'd0, OF}, 64'd1);

      drive(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      check("sub_mixed_out", out, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_mixed_OF", {63'd0, OF}, 64'd0);

      drive(2'd1, 64'd3, 64'd10);
      check("sub_order_out", out, 64'hFFFF_FFFF_FFFF_FFF9);

      drive(2'd2, 64'hF0F0, 64'hFF00);
      check("and_out", out, 64'hF000);
      check("and_OF", {63'd0, OF}, 64'd0);

      drive(2'd3, 64'hF0F0, 64'hFF00);
      check("xor_out", out, 64'h0FF0);
      check("xor_OF", {63'd0, OF}, 64'd0);

      drive(2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      check("xor_noovf_out", out, 64'h7FFF_FFFF_FFFF_FFFE);
      check("xor_noovf_OF", {63'd0, OF}, 64'd0);

      drive(2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      check("and_msb_out", out, 64'h8000_0000_0000_0000);
      check("and_msb_OF", {63'd0, OF}, 64'd0);

      // Carry out of the MSB without signed overflow.
      drive(2'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd16);
      check("add_carry_out", out, 64'd8);
      check("add_carry_OF", {63'd0, OF}, 64'd0);
      tick();
      check("add_carry_out_q", out_q, 64'd8);

      reset = 1'b1;
      tick();
      check("rst_out_q", out_q, 64'd0);
      check("rst_OF_q", {63'd0, OF_q}, 64'd0);
      check("rst_comb_out", out, 64'd8);
      reset = 1'b0;
      tick();
      check("post_rst_out_q", out_q, 64'd8);

      // Registered overflow flag must also clear on reset.
      drive(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      tick();
      check("of_set_OF_q", {63'd0, OF_q}, 64'd1);
      reset = 1'b1;
      tick();
      check("of_rst_OF_q", {63'd0, OF_q}, 64'd0);
      check("of_rst_comb_OF", {63'd0, OF}, 64'd1);
      reset = 1'b0;
      tick();
      check("of_post_rst_OF_q", {63'd0, OF_q}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_wrapper.md
ALU_WRAPPER -- requirements
Module: alu_wrapper

Interface
REQ-001 Parameter: WIDTH, default 64, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all registered state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: OF  output  1  combinational signed-overflow flag for the current operation.
REQ-005 Port: out  output  WIDTH  combinational ALU result.
REQ-006 Port: fun  input  2  operation select: 0 add, 1 sub, 2 and, 3 xor.
REQ-007 Port: b  input  WIDTH  first operand (minuend for sub).
REQ-008 Port: a  input  WIDTH  second operand (subtrahend for sub).
REQ-009 Port: out_q  output  WIDTH  registered copy of out.
REQ-010 Port: OF_q  output  1  registered copy of OF.
REQ-011 Positional declaration order SHALL be OF, out, fun, b, a, clk, reset, out_q, OF_q, so existing five-port positional instantiations in the execute stage still bind correctly.

Function
REQ-012 out and OF SHALL be purely combinational from fun, a and b, with zero latency, so a same-evaluation read of out by the execute stage sees the new result.
REQ-013 fun=0 SHALL give out = b + a modulo 2^WIDTH, with carry out discarded.
REQ-014 fun=1 SHALL give out = b - a modulo 2^WIDTH, following Y86 subq order (valB - valA).
REQ-015 fun=2 SHALL give out = b AND a, bitwise.
REQ-016 fun=3 SHALL give out = b XOR a, bitwise.
REQ-017 For add, OF SHALL be 1 iff a[MSB]==b[MSB] and out[MSB]!=a[MSB].
REQ-018 For sub, OF SHALL be 1 iff b[MSB]!=a[MSB] and out[MSB]!=b[MSB].
REQ-019 For and and xor, OF SHALL be 0.
REQ-020 Operands SHALL be treated as two's-complement for OF; the arithmetic is identical for signed and unsigned values.
REQ-021 On each rising clk edge without reset, out_q SHALL take out and OF_q SHALL take OF, giving one-cycle latency.
REQ-022 No X SHALL propagate for any legal 2-bit fun; all four codes are defined.

Reset
REQ-023 When reset=1 at a rising clk edge, out_q SHALL become 0 and OF_q SHALL become 0.
REQ-024 Reset SHALL have no effect on the combinational outputs out and OF.
REQ-025 In the first clk edge after reset deasserts, out_q and OF_q SHALL capture the current combinational values.

Structure
REQ-026 A shared package SHALL hold the function codes ALUADD=0, ALUSUB=1, ALUAND=2, ALUXOR=3, and the default width 64.
REQ-027 One sub-module, alu_add64, SHALL implement a WIDTH-bit adder with carry-in.
REQ-028 alu_add64 SHALL serve both add and sub, implementing sub as b + ~a + 1.
REQ-029 Operation select, overflow logic and the output registers SHALL stay in alu_wrapper.

Verification
REQ-030 fun=0, b=5, a=3 -> out=8, OF=0; out_q=8 after one clk edge.
REQ-031 fun=0, b=0x7FFFFFFFFFFFFFFF, a=1 -> out=0x8000000000000000, OF=1.
REQ-032 fun=1, b=10, a=3 -> out=7, OF=0; then fun=1, b=0x8000000000000000, a=1 -> out=0x7FFFFFFFFFFFFFFF, OF=1.
REQ-033 fun=2, b=0xF0F0, a=0xFF00 -> out=0xF000, OF=0; fun=3 with the same operands -> out=0x0FF0, OF=0.
REQ-034 fun=0, b=-8 (0xFFFFFFFFFFFFFFF8), a=16 -> out=8, OF=0, which checks that carry out does not set OF.
REQ-035 reset=1 for one edge with out=8 -> out_q=0 and OF_q=0, while out stays 8; after reset deasserts, the next edge gives out_q=8.
